div_unit: RTL and testbench

Iterative radix-2 integer divider for the RV32 core's M-extension path (DIV, DIVU, REM, REMU). It is the sequential counterpart to the single-cycle ALU: the execute stage hands it operands with a start pulse, it stalls the pipeline through `busy`, and it returns a 32-bit result with a one-cycle `done` pulse. A `kill` input lets the trap logic abandon an in-flight division when the instruction is flushed.

---
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow complete in a single cycle.
module div_unit #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] y
);

    localparam int CW = $clog2(size + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [size-1:0] ALL_ONES = {size{1'b1}};
    localparam logic [size-1:0] ZERO     = {size{1'b0}};
    localparam logic [size-1:0] MIN_NEG  = {1'b1, {(size-1){1'b0}}};

    logic [1:0]      state_r, state_nxt_s;
    logic            rem_r, rem_nxt_s;
    logic            neg_q_r, neg_q_nxt_s;
    logic            neg_r_r, neg_r_nxt_s;
    logic [size-1:0] r_r, r_nxt_s;
    logic [size-1:0] q_r, q_nxt_s;
    logic [size-1:0] d_r, d_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic [size-1:0] y_r, y_nxt_s;

    logic            accept_s;
    logic            signed_op_s;
    logic            a_neg_s, b_neg_s;
    logic [size-1:0] abs_a_s, abs_b_s;
    logic [size:0]   r_sh_s;
    logic            ge_s;
    logic [size-1:0] diff_s;
    logic [size-1:0] q_fix_s, r_fix_s;

    assign accept_s    = start && !kill && ((state_r == IDLE) || (state_r == DONE));
    assign signed_op_s = ~op[0];
    assign a_neg_s     = signed_op_s & a[size-1];
    assign b_neg_s     = signed_op_s & b[size-1];
    assign abs_a_s     = a_neg_s ? (ZERO - a) : a;
    assign abs_b_s     = b_neg_s ? (ZERO - b) : b;

    // The stored remainder never exceeds |b|, so only the shifted value needs the extra bit.
    assign r_sh_s  = {r_r, q_r[size-1]};
    assign ge_s    = r_sh_s >= {1'b0, d_r};
    assign diff_s  = r_sh_s[size-1:0] - d_r;
    assign q_fix_s = neg_q_r ? (ZERO - q_r) : q_r;
    assign r_fix_s = neg_r_r ? (ZERO - r_r) : r_r;

    // Next-state and datapath update for every register.
    always_comb begin
        state_nxt_s = state_r;
        rem_nxt_s   = rem_r;
        neg_q_nxt_s = neg_q_r;
        neg_r_nxt_s = neg_r_r;
        r_nxt_s     = r_r;
        q_nxt_s     = q_r;
        d_nxt_s     = d_r;
        cnt_nxt_s   = cnt_r;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        y_nxt_s     = y_r;
        if (kill) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        rem_nxt_s   = op[1];
                        neg_q_nxt_s = a_neg_s ^ b_neg_s;
                        neg_r_nxt_s = a_neg_s;
                        r_nxt_s     = ZERO;
                        q_nxt_s     = abs_a_s;
                        d_nxt_s     = abs_b_s;
                        cnt_nxt_s   = CW'(size);
                        if (b == ZERO) begin
                            y_nxt_s     = op[1] ? a : ALL_ONES;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = DONE;
                        end else if (signed_op_s && (a == MIN_NEG) && (b == ALL_ONES)) begin
                            y_nxt_s     = op[1] ? ZERO : MIN_NEG;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = DONE;
                        end else begin
                            busy_nxt_s  = 1'b1;
                            state_nxt_s = CALC;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    busy_nxt_s = 1'b1;
                    q_nxt_s    = {q_r[size-2:0], ge_s};
                    if (ge_s) begin
                        r_nxt_s = diff_s;
                    end else begin
                        r_nxt_s = r_sh_s[size-1:0];
                    end
                    cnt_nxt_s = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                FIX: begin
                    y_nxt_s     = rem_r ? r_fix_s : q_fix_s;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = DONE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rem_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            r_r     <= ZERO;
            q_r     <= ZERO;
            d_r     <= ZERO;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            y_r     <= ZERO;
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
            neg_q_r <= neg_q_nxt_s;
            neg_r_r <= neg_r_nxt_s;
            r_r     <= r_nxt_s;
            q_r     <= q_nxt_s;
            d_r     <= d_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            y_r     <= y_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign y    = y_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: timing, signed/unsigned results,
// special cases, kill, ignored start, asynchronous reset and back-to-back requests.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int n_checks = 0;
    int n_fail   = 0;
    bit overlap_seen = 1'b0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.size(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .kill  (kill),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap_seen = 1'b1;
    end

    // Presents a request so that the next rising edge is cycle 0.
    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one request; reports done cycle (-1 on timeout), busy cycles and y at done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output int done_cyc, output int busy_cnt, output logic [31:0] yv);
        done_cyc = -1; busy_cnt = 0; yv = 32'hx;
        issue(o, aa, bb);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc; yv = y;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (y !== 32'h0) begin n_fail++; $display("FAIL reset_y got %h want 00000000", y); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int dc, bc; logic [31:0] yv;
        run_op(OP_DIV, 32'd100, 32'd7, dc, bc, yv);
        n_checks++; if (yv !== 32'd14) begin n_fail++; $display("FAIL div_100_7 got %h want 0000000e", yv); end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL div_done_cycle got %0d want 34", dc); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 33", bc); end
        run_op(OP_REM, 32'd100, 32'd7, dc, bc, yv);
        n_checks++; if (yv !== 32'd2) begin n_fail++; $display("FAIL rem_100_7 got %h want 00000002", yv); end
    endtask

    task automatic test_signed();
        int dc, bc; logic [31:0] yv;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, dc, bc, yv);
        n_checks++; if (yv !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_m7_2 got %h want fffffffd", yv); end
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, dc, bc, yv);
        n_checks++; if (yv !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_m7_2 got %h want ffffffff", yv); end
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, dc, bc, yv);
        n_checks++; if (yv !== 32'h7FFFFFFC) begin n_fail++; $display("FAIL divu_m7_2 got %h want 7ffffffc", yv); end
        run_op(OP_REMU, 32'hFFFFFFF9, 32'd2, dc, bc, yv);
        n_checks++; if (yv !== 32'd1) begin n_fail++; $display("FAIL remu_m7_2 got %h want 00000001", yv); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, dc, bc, yv);
        n_checks++; if (yv !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_7_m2 got %h want fffffffd", yv); end
        run_op(OP_REM, 32'd7, 32'hFFFFFFFE, dc, bc, yv);
        n_checks++; if (yv !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2 got %h want 00000001", yv); end
    endtask

    task automatic test_div_zero();
        int dc, bc; logic [31:0] yv;
        run_op(OP_DIV, 32'd5, 32'd0, dc, bc, yv);
        n_checks++; if (yv !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_y got %h want ffffffff", yv); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL div0_done_cycle got %0d want 1", dc); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL div0_busy got %0d want 0", bc); end
        run_op(OP_REMU, 32'd5, 32'd0, dc, bc, yv);
        n_checks++; if (yv !== 32'd5) begin n_fail++; $display("FAIL remu0_y got %h want 00000005", yv); end
    endtask

    task automatic test_overflow();
        int dc, bc; logic [31:0] yv;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, dc, bc, yv);
        n_checks++; if (yv !== 32'h80000000) begin n_fail++; $display("FAIL ovf_div got %h want 80000000", yv); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ovf_done_cycle got %0d want 1", dc); end
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, dc, bc, yv);
        n_checks++; if (yv !== 32'h0) begin n_fail++; $display("FAIL ovf_rem got %h want 00000000", yv); end
    endtask

    task automatic test_ignored_start();
        int dc = -1; logic [31:0] yv = 32'hx;
        issue(OP_DIV, 32'd100, 32'd7);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) begin dc = cyc; yv = y; break; end
            if (cyc == 5) begin
                start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL ignstart_done_cycle got %0d want 34", dc); end
        n_checks++; if (yv !== 32'd14) begin n_fail++; $display("FAIL ignstart_y got %h want 0000000e", yv); end
    endtask

    task automatic test_kill();
        int done_seen = 0;
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (cyc == 10) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill_busy_before got %b want 1", busy); end
                kill = 1'b1;
            end else if (cyc == 11) begin
                kill = 1'b0;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy_after got %b want 0", busy); end
            end else begin
                kill = 1'b0;
            end
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL kill_no_done got %0d want 0", done_seen); end
        n_checks++; if (y !== 32'd14) begin n_fail++; $display("FAIL kill_y_kept got %h want 0000000e", y); end
        // kill wins over a simultaneous divide-by-zero request that would otherwise finish in one cycle
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = OP_DIV; a = 32'd5; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0; kill = 1'b0;
        done_seen = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL kill_start_accepted got %0d want 0", done_seen); end
        n_checks++; if (y !== 32'd14) begin n_fail++; $display("FAIL kill_start_y got %h want 0000000e", y); end
    endtask

    task automatic test_reset_mid();
        issue(OP_DIV, 32'd100, 32'd7);
        for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
        n_checks++; if (y !== 32'h0) begin n_fail++; $display("FAIL rstmid_y got %h want 00000000", y); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int dc1 = -1, dc2 = -1; logic [31:0] y1 = 32'hx, y2 = 32'hx;
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd1);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                dc1 = cyc; y1 = y;
                break;
            end
        end
        // second request is presented in the first request's done cycle
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                dc2 = cyc; y2 = y;
                break;
            end
        end
        n_checks++; if (y1 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_first_y got %h want ffffffff", y1); end
        n_checks++; if (dc1 !== 34) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 34", dc1); end
        n_checks++; if (dc2 !== 34) begin n_fail++; $display("FAIL b2b_second_cycle got %0d want 34", dc2); end
        n_checks++; if (y2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_y got %h want 0000000e", y2); end
        n_checks++; if (overlap_seen !== 1'b0) begin n_fail++; $display("FAIL busy_done_overlap got %b want 0", overlap_seen); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignored_start();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
